// File: rtl/can_pkg.sv
// -----------------------------------------------------------------------------
// can_pkg
// Shared definitions for the CAN receive path: the bit sampler state encoding,
// bus-level protocol limits, and constant functions that turn the clock/bit-rate
// parameters into bit-timer values. Later Rx stages import the same package.
// -----------------------------------------------------------------------------
package can_pkg;

   // Bit sampler states.
   typedef enum logic [1:0] {
      ST_WAIT_IDLE = 2'd0,  // counting recessive bits before the bus is usable
      ST_IDLE      = 2'd1,  // bus idle, waiting for a hard-sync edge (SOF)
      ST_FRAME     = 2'd2   // frame in progress, sampling and de-stuffing
   } can_state_e;

   // Consecutive recessive bits that declare the bus idle.
   localparam logic [3:0] IDLE_BITS   = 4'd11;
   // Equal consecutive bits after which a stuff bit of opposite value follows.
   localparam logic [2:0] STUFF_LIMIT = 3'd5;

   // System clocks per CAN bit (integer division).
   function automatic int unsigned calc_bit_clks(input int unsigned clk_mhz,
                                                 input int unsigned rate_kbits);
      return (clk_mhz * 32'd1000) / rate_kbits;
   endfunction

   // Bit-timer value of the sample point (integer division).
   function automatic int unsigned calc_sample_clk(input int unsigned bit_clks,
                                                   input int unsigned pct);
      return (bit_clks * pct) / 32'd100;
   endfunction

endpackage

// File: rtl/can_rx_sync.sv
// -----------------------------------------------------------------------------
// can_rx_sync
// Two-flop synchroniser for the asynchronous CAN Rx pin plus recessive-to-
// dominant edge detection. All flops reset to recessive (1) so a reset never
// manufactures a falling edge.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   rx      in   raw CAN Rx pin (asynchronous, 1 = recessive)
//   rx_s    out  synchronised Rx level
//   fall_s  out  high for one cycle when rx_s goes 1 -> 0
// -----------------------------------------------------------------------------
module can_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_s,
   output logic fall_s
);

   logic meta_r;
   logic sync_r;
   logic prev_r;

   // Synchroniser chain plus one history flop for the edge detector.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_r <= 1'b1;
         sync_r <= 1'b1;
         prev_r <= 1'b1;
      end else begin
         meta_r <= rx;
         sync_r <= meta_r;
         prev_r <= sync_r;
      end
   end

   assign rx_s   = sync_r;
   assign fall_s = prev_r & ~sync_r;

endmodule

// File: rtl/can_bit_sampler.sv
// -----------------------------------------------------------------------------
// can_bit_sampler
// Front end of the CAN receive path. Synchronises Rx, hard-syncs the bit timer
// on every recessive-to-dominant edge, samples each bit at the programmable
// sample point, removes stuff bits and flags stuff violations. Delivers one
// din/dvalid pair per de-stuffed bit and an sof pulse on the first bit.
//
// Parameters:
//   clk_speed_MHz       system clock frequency in MHz
//   can_bit_rate_Kbits  CAN bit rate in kbit/s
//   sample_point_pct    sample point as a percentage of the bit time
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   rx           in   raw CAN Rx pin (asynchronous, 1 = recessive)
//   sample_en    in   high while the frame length calculator sees a frame
//   destuff_dis  in   high from the CRC delimiter onward (no de-stuffing)
//   din          out  de-stuffed sampled bit, valid with dvalid
//   dvalid       out  one-cycle pulse per delivered bit
//   sof          out  one-cycle pulse with the dvalid of the SOF bit
//   stuff_error  out  one-cycle pulse on a stuff violation
//   bus_idle     out  high while the sampler is in IDLE
// -----------------------------------------------------------------------------
module can_bit_sampler
   import can_pkg::*;
#(
   parameter int unsigned clk_speed_MHz      = 100,
   parameter int unsigned can_bit_rate_Kbits = 1000,
   parameter int unsigned sample_point_pct   = 75
) (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   input  logic sample_en,
   input  logic destuff_dis,
   output logic din,
   output logic dvalid,
   output logic sof,
   output logic stuff_error,
   output logic bus_idle
);

   localparam int unsigned BIT_CLKS   = calc_bit_clks(clk_speed_MHz, can_bit_rate_Kbits);
   localparam int unsigned SAMPLE_CLK = calc_sample_clk(BIT_CLKS, sample_point_pct);
   localparam int unsigned TIMER_W    = (BIT_CLKS > 32'd1) ? $clog2(BIT_CLKS) : 32'd1;

   localparam logic [TIMER_W-1:0] TIMER_ZERO   = {TIMER_W{1'b0}};
   localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(32'd1);
   localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(BIT_CLKS - 32'd1);
   localparam logic [TIMER_W-1:0] TIMER_SAMPLE = TIMER_W'(SAMPLE_CLK);

   // Synchroniser outputs.
   logic rx_s;
   logic fall_s;

   // Bit timer.
   logic [TIMER_W-1:0] timer_r;
   logic [TIMER_W-1:0] timer_eff_s;
   logic [TIMER_W-1:0] timer_next_s;
   logic               sample_s;

   // Frame-end detection on sample_en.
   logic en_prev_r;
   logic en_fall_s;

   // FSM and de-stuffing state.
   can_state_e state_r;
   can_state_e state_next_s;
   logic [3:0] rec_cnt_r;
   logic [3:0] rec_cnt_next_s;
   logic [2:0] stuff_cnt_r;
   logic [2:0] stuff_cnt_next_s;
   logic       last_bit_r;
   logic       last_bit_next_s;
   logic       first_r;
   logic       first_next_s;

   // Registered outputs and their next values.
   logic din_r;
   logic dvalid_r;
   logic sof_r;
   logic stuff_err_r;
   logic bus_idle_r;
   logic din_next_s;
   logic dvalid_next_s;
   logic sof_next_s;
   logic stuff_err_next_s;

   can_rx_sync u_rx_sync (
      .clk    (clk),
      .rst    (rst),
      .rx     (rx),
      .rx_s   (rx_s),
      .fall_s (fall_s)
   );

   assign en_fall_s = en_prev_r & ~sample_en;

   // Current bit-time position and sample strobe; a falling edge makes the
   // current cycle position 0, so a resync on the sample cycle suppresses it.
   always_comb begin
      timer_eff_s  = timer_r;
      timer_next_s = TIMER_ZERO;
      if (fall_s) begin
         timer_eff_s = TIMER_ZERO;
      end else begin
         timer_eff_s = timer_r;
      end
      if (timer_eff_s == TIMER_LAST) begin
         timer_next_s = TIMER_ZERO;
      end else begin
         timer_next_s = timer_eff_s + TIMER_ONE;
      end
      sample_s = (timer_eff_s == TIMER_SAMPLE) && !fall_s;
   end

   // Next-state, de-stuffing and output decode.
   always_comb begin
      state_next_s     = state_r;
      rec_cnt_next_s   = rec_cnt_r;
      stuff_cnt_next_s = stuff_cnt_r;
      last_bit_next_s  = last_bit_r;
      first_next_s     = first_r;
      dvalid_next_s    = 1'b0;
      din_next_s       = 1'b0;
      sof_next_s       = 1'b0;
      stuff_err_next_s = 1'b0;

      case (state_r)
         ST_WAIT_IDLE: begin
            if (sample_s) begin
               if (rx_s) begin
                  if (rec_cnt_r == (IDLE_BITS - 4'd1)) begin
                     state_next_s   = ST_IDLE;
                     rec_cnt_next_s = 4'd0;
                  end else begin
                     rec_cnt_next_s = rec_cnt_r + 4'd1;
                  end
               end else begin
                  rec_cnt_next_s = 4'd0;
               end
            end else begin
               rec_cnt_next_s = rec_cnt_r;
            end
         end

         ST_IDLE: begin
            if (fall_s) begin
               state_next_s = ST_FRAME;
               first_next_s = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end

         ST_FRAME: begin
            // Frame end outranks a coincident sample point.
            if (en_fall_s) begin
               state_next_s = ST_IDLE;
               first_next_s = 1'b0;
            end else if (sample_s) begin
               if (first_r) begin
                  first_next_s = 1'b0;
                  if (!rx_s) begin
                     dvalid_next_s    = 1'b1;
                     din_next_s       = 1'b0;
                     sof_next_s       = 1'b1;
                     stuff_cnt_next_s = 3'd1;
                     last_bit_next_s  = 1'b0;
                  end else begin
                     // Recessive at the SOF sample point: the edge was a glitch.
                     state_next_s = ST_IDLE;
                  end
               end else if (destuff_dis) begin
                  dvalid_next_s    = 1'b1;
                  din_next_s       = rx_s;
                  stuff_cnt_next_s = 3'd1;
                  last_bit_next_s  = rx_s;
               end else if (stuff_cnt_r >= STUFF_LIMIT) begin
                  // This bit is a stuff bit; it must differ from the run before it.
                  if (rx_s == last_bit_r) begin
                     stuff_err_next_s = 1'b1;
                     state_next_s     = ST_WAIT_IDLE;
                     rec_cnt_next_s   = 4'd0;
                  end else begin
                     stuff_cnt_next_s = 3'd1;
                     last_bit_next_s  = rx_s;
                  end
               end else begin
                  dvalid_next_s   = 1'b1;
                  din_next_s      = rx_s;
                  last_bit_next_s = rx_s;
                  // Count is below the limit here, so +1 saturates at the limit.
                  if (rx_s == last_bit_r) begin
                     stuff_cnt_next_s = stuff_cnt_r + 3'd1;
                  end else begin
                     stuff_cnt_next_s = 3'd1;
                  end
               end
            end else begin
               state_next_s = ST_FRAME;
            end
         end

         default: begin
            state_next_s   = ST_WAIT_IDLE;
            rec_cnt_next_s = 4'd0;
         end
      endcase
   end

   // State register, bit timer and de-stuffing history.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_WAIT_IDLE;
         timer_r     <= TIMER_ZERO;
         rec_cnt_r   <= 4'd0;
         stuff_cnt_r <= 3'd0;
         last_bit_r  <= 1'b1;
         first_r     <= 1'b0;
         en_prev_r   <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         timer_r     <= timer_next_s;
         rec_cnt_r   <= rec_cnt_next_s;
         stuff_cnt_r <= stuff_cnt_next_s;
         last_bit_r  <= last_bit_next_s;
         first_r     <= first_next_s;
         en_prev_r   <= sample_en;
      end
   end

   // Output registers; bus_idle follows the state register by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         din_r       <= 1'b0;
         dvalid_r    <= 1'b0;
         sof_r       <= 1'b0;
         stuff_err_r <= 1'b0;
         bus_idle_r  <= 1'b0;
      end else begin
         din_r       <= din_next_s;
         dvalid_r    <= dvalid_next_s;
         sof_r       <= sof_next_s;
         stuff_err_r <= stuff_err_next_s;
         bus_idle_r  <= (state_r == ST_IDLE);
      end
   end

   assign din         = din_r;
   assign dvalid      = dvalid_r;
   assign sof         = sof_r;
   assign stuff_error = stuff_err_r;
   assign bus_idle    = bus_idle_r;

endmodule

// File: tb/tb_can_bit_sampler.sv
// -----------------------------------------------------------------------------
// tb_can_bit_sampler
// Directed bench for can_bit_sampler at default parameters (100 clocks/bit,
// sample at 75). Stimulus pushes expected output events (fields + cycle of
// appearance) into a queue; a negedge monitor pops and compares whenever the
// DUT pulses dvalid, sof or stuff_error. Level checks cover reset and bus_idle.
// -----------------------------------------------------------------------------
module tb_can_bit_sampler;

   localparam int BIT = 100;

   logic clk = 1'b0;
   logic rst;
   logic rx;
   logic sample_en;
   logic destuff_dis;
   logic din;
   logic dvalid;
   logic sof;
   logic stuff_error;
   logic bus_idle;

   int unsigned cyc = 32'd0;
   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic        dv;
      logic        din;
      logic        sof;
      logic        serr;
      int unsigned cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t got_e;

   can_bit_sampler #(
      .clk_speed_MHz      (100),
      .can_bit_rate_Kbits (1000),
      .sample_point_pct   (75)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .sample_en   (sample_en),
      .destuff_dis (destuff_dis),
      .din         (din),
      .dvalid      (dvalid),
      .sof         (sof),
      .stuff_error (stuff_error),
      .bus_idle    (bus_idle)
   );

   always #5 clk = ~clk;

   // Cycle counter: number of rising edges seen so far.
   always @(posedge clk) cyc <= cyc + 32'd1;

   // Monitor: compare every output event against the head of the queue.
   always @(negedge clk) begin
      if (dvalid || sof || stuff_error) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got dv=%0b din=%0b sof=%0b serr=%0b at cyc %0d, required no event",
                     dvalid, din, sof, stuff_error, cyc);
         end else begin
            got_e = exp_q.pop_front();
            tests++;
            if ({dvalid, din, sof, stuff_error} !== {got_e.dv, got_e.din, got_e.sof, got_e.serr}) begin
               fails++;
               $display("FAIL event_fields: got dv/din/sof/serr=%b%b%b%b, required %b%b%b%b (cyc %0d)",
                        dvalid, din, sof, stuff_error, got_e.dv, got_e.din, got_e.sof, got_e.serr, cyc);
            end
            tests++;
            if (cyc != got_e.cyc) begin
               fails++;
               $display("FAIL event_time: got cyc %0d, required cyc %0d", cyc, got_e.cyc);
            end
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int unsigned target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic act, input logic req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0b, required %0b (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic expect_ev(input logic dv, input logic d, input logic s,
                            input logic e, input int unsigned at);
      exp_t x;
      x.dv   = dv;
      x.din  = d;
      x.sof  = s;
      x.serr = e;
      x.cyc  = at;
      exp_q.push_back(x);
   endtask

   task automatic check_all_low(input string name);
      check({name, "_din"}, din, 1'b0);
      check({name, "_dvalid"}, dvalid, 1'b0);
      check({name, "_sof"}, sof, 1'b0);
      check({name, "_stuff_error"}, stuff_error, 1'b0);
      check({name, "_bus_idle"}, bus_idle, 1'b0);
   endtask

   // Drive bits[0..n-1] one bit time each with sample_en high, then end the frame.
   task automatic send_frame(input logic [15:0] bits, input int n, input logic dd);
      sample_en = 1'b1;
      for (int i = 0; i < n; i++) begin
         destuff_dis = (i >= 1) ? dd : 1'b0;
         rx = bits[i];
         tick(BIT);
      end
      sample_en   = 1'b0;
      destuff_dis = 1'b0;
      rx          = 1'b1;
      tick(2 * BIT);
   endtask

   int unsigned r;
   int unsigned p;
   int unsigned q;

   initial begin
      rst         = 1'b1;
      rx          = 1'b1;
      sample_en   = 1'b0;
      destuff_dis = 1'b0;
      tick(3);
      check_all_low("reset");

      // Power-up: 11 recessive samples (last at timer 75 of the 11th bit) -> IDLE.
      rst = 1'b0;
      r   = cyc;
      wait_until(r + 32'd1050);
      check("bus_idle_before_11th", bus_idle, 1'b0);
      wait_until(r + 32'd1100);
      check("bus_idle_after_11th", bus_idle, 1'b1);

      // Single SOF bit: dvalid/sof 78 cycles after the pin edge, then frame end.
      p = cyc;
      expect_ev(1'b1, 1'b0, 1'b1, 1'b0, p + 32'd78);
      sample_en = 1'b1;
      rx        = 1'b0;
      tick(50);
      check("bus_idle_in_frame", bus_idle, 1'b0);
      tick(50);
      sample_en = 1'b0;
      rx        = 1'b1;
      tick(10);
      check("bus_idle_after_exit", bus_idle, 1'b1);
      tick(2 * BIT);

      // 10-cycle dominant glitch: frame entered, recessive at sample -> IDLE.
      p  = cyc;
      rx = 1'b0;
      tick(10);
      rx = 1'b1;
      wait_until(p + 32'd40);
      check("glitch_frame_entered", bus_idle, 1'b0);
      wait_until(p + 32'd100);
      check("glitch_back_idle", bus_idle, 1'b1);
      tick(BIT);

      // SOF + four 0s + stuff 1 + data 1: stuff bit removed, 200-cycle gap.
      p = cyc;
      for (int k = 0; k < 5; k++) begin
         expect_ev(1'b1, 1'b0, (k == 0), 1'b0, p + 32'd78 + 32'(k * BIT));
      end
      expect_ev(1'b1, 1'b1, 1'b0, 1'b0, p + 32'd678);
      send_frame(16'h0060, 7, 1'b0);
      check("bus_idle_after_stuff_frame", bus_idle, 1'b1);

      // Six dominant bits: stuff error at the 6th sample, then WAIT_IDLE.
      p = cyc;
      for (int k = 0; k < 5; k++) begin
         expect_ev(1'b1, 1'b0, (k == 0), 1'b0, p + 32'd78 + 32'(k * BIT));
      end
      expect_ev(1'b0, 1'b0, 1'b0, 1'b1, p + 32'd578);
      send_frame(16'h0000, 6, 1'b0);
      check("bus_idle_after_stuff_err", bus_idle, 1'b0);
      wait_until(p + 32'd1650);
      check("bus_idle_wait_10_recessive", bus_idle, 1'b0);
      wait_until(p + 32'd2000);
      check("bus_idle_recovered", bus_idle, 1'b1);

      // De-stuffing disabled after SOF: seven dominant bits all delivered.
      p = cyc;
      for (int k = 0; k < 7; k++) begin
         expect_ev(1'b1, 1'b0, (k == 0), 1'b0, p + 32'd78 + 32'(k * BIT));
      end
      send_frame(16'h0000, 7, 1'b1);
      check("bus_idle_after_destuff_dis", bus_idle, 1'b1);

      // Reset mid-frame, then sample_en dropped.
      p = cyc;
      expect_ev(1'b1, 1'b0, 1'b1, 1'b0, p + 32'd78);
      expect_ev(1'b1, 1'b1, 1'b0, 1'b0, p + 32'd178);
      sample_en = 1'b1;
      rx        = 1'b0;
      tick(BIT);
      rx = 1'b1;
      tick(BIT + 50);
      rst = 1'b1;
      tick(1);
      check_all_low("mid_frame_reset");
      tick(1);
      rst       = 1'b0;
      sample_en = 1'b0;
      tick(3 * BIT);
      // A dominant bit before 11 recessive bits: no SOF, recessive count restarts.
      q  = cyc;
      rx = 1'b0;
      tick(BIT);
      rx = 1'b1;
      wait_until(q + 32'd1100);
      check("post_reset_not_idle", bus_idle, 1'b0);
      wait_until(q + 32'd1250);
      check("post_reset_idle", bus_idle, 1'b1);
      p = cyc;
      expect_ev(1'b1, 1'b0, 1'b1, 1'b0, p + 32'd78);
      send_frame(16'h0000, 1, 1'b0);

      tick(10);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
